// File: rtl/bp_cfg_field_broadcaster_if.sv
// Boot/host control, config ROM port and per-channel cfg packet links of bp_cfg_field_broadcaster.
// master = broadcaster side, slave = controller/ROM/endpoint side.
`timescale 1ns/1ps
interface bp_cfg_field_broadcaster_if #(
  parameter int unsigned num_cfgs_p    = 128,
  parameter int unsigned field_count_p = 32,
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned num_ch_p      = 4
);
  localparam int unsigned lg_cfgs_lp   = $clog2(num_cfgs_p);
  localparam int unsigned lg_fields_lp = $clog2(field_count_p + 1);

  logic                                 start_i;
  logic [lg_cfgs_lp-1:0]                cfg_sel_i;
  logic [num_ch_p-1:0]                  ch_en_i;
  logic                                 rom_v_o;
  logic [lg_cfgs_lp+lg_fields_lp-1:0]   rom_addr_o;
  logic [data_width_p-1:0]              rom_data_i;
  logic [num_ch_p-1:0]                  pkt_v_o;
  logic [lg_fields_lp-1:0]              pkt_addr_o;
  logic [data_width_p-1:0]              pkt_data_o;
  logic [num_ch_p-1:0]                  pkt_ready_i;
  logic                                 busy_o;
  logic                                 done_o;
  logic                                 error_o;

  modport master (
    input  start_i, cfg_sel_i, ch_en_i, rom_data_i, pkt_ready_i,
    output rom_v_o, rom_addr_o, pkt_v_o, pkt_addr_o, pkt_data_o, busy_o, done_o, error_o
  );

  modport slave (
    output start_i, cfg_sel_i, ch_en_i, rom_data_i, pkt_ready_i,
    input  rom_v_o, rom_addr_o, pkt_v_o, pkt_addr_o, pkt_data_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/bp_cfg_field_broadcaster.sv
// Streams one config from a 1-cycle-latency ROM, field by field, to several cfg endpoints.
// Optional BP_CFG_CHECKSUM_EN appends an XOR checksum beat (addr = field_count_p) after the last field.
`timescale 1ns/1ps
module bp_cfg_field_broadcaster #(
  parameter int unsigned num_cfgs_p    = 128,
  parameter int unsigned field_count_p = 32,
  parameter int unsigned data_width_p  = 64,
  parameter int unsigned num_ch_p      = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  bp_cfg_field_broadcaster_if.master bus
);
  localparam int unsigned lg_cfgs_lp   = $clog2(num_cfgs_p);
  localparam int unsigned lg_fields_lp = $clog2(field_count_p + 1);
  localparam int unsigned rom_aw_lp    = lg_cfgs_lp + lg_fields_lp;
  localparam logic [lg_fields_lp-1:0] last_idx_lp = lg_fields_lp'(field_count_p - 1);
`ifdef BP_CFG_CHECKSUM_EN
  localparam logic [lg_fields_lp-1:0] sum_idx_lp  = lg_fields_lp'(field_count_p);
`endif

  typedef enum logic [2:0] {st_idle, st_fetch, st_wait, st_send, st_done} state_e;

  state_e                  state_q, state_n;
  logic [lg_cfgs_lp-1:0]   cfg_q, cfg_n;
  logic [num_ch_p-1:0]     ch_en_q, ch_en_n;
  logic [lg_fields_lp-1:0] idx_q, idx_n;
  logic [data_width_p-1:0] data_q, data_n;
  logic [num_ch_p-1:0]     pend_q, pend_n;
  logic                    err_q, err_n;
  logic                    rom_v_q, rom_v_n;
  logic [rom_aw_lp-1:0]    rom_addr_q, rom_addr_n;
  logic                    busy_q, busy_n;
  logic                    done_q, done_n;
`ifdef BP_CFG_CHECKSUM_EN
  logic [data_width_p-1:0] csum_q, csum_n;
`endif

  logic [num_ch_p-1:0] pend_left;
  logic                beat_done;
  logic                last_beat;
  logic                start_ok;

  // Channels still owed the current beat once this cycle's handshakes land.
  assign pend_left = pend_q & ~bus.pkt_ready_i;
  assign beat_done = (pend_left == '0);
  assign start_ok  = bus.start_i && (bus.cfg_sel_i != '0);
`ifdef BP_CFG_CHECKSUM_EN
  assign last_beat = (idx_q == sum_idx_lp);
`else
  assign last_beat = (idx_q == last_idx_lp);
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= st_idle;
    else            state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      st_idle:  if (start_ok) state_n = st_fetch;
      st_fetch: state_n = st_wait;
      st_wait:  state_n = st_send;
      st_send: begin
        if (beat_done) begin
          if (last_beat) begin
            state_n = st_done;
          end else begin
`ifdef BP_CFG_CHECKSUM_EN
            state_n = (idx_q == last_idx_lp) ? st_send : st_fetch;
`else
            state_n = st_fetch;
`endif
          end
        end
      end
      st_done:  state_n = st_idle;
      default:  state_n = st_idle;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cfg_n   = cfg_q;
    ch_en_n = ch_en_q;
    idx_n   = idx_q;
    data_n  = data_q;
    pend_n  = pend_q;
    err_n   = err_q;
`ifdef BP_CFG_CHECKSUM_EN
    csum_n  = csum_q;
`endif
    case (state_q)
      st_idle: begin
        if (bus.start_i) begin
          if (bus.cfg_sel_i == '0) begin
            err_n = 1'b1;
          end else begin
            err_n   = 1'b0;
            cfg_n   = bus.cfg_sel_i;
            ch_en_n = bus.ch_en_i;
            idx_n   = '0;
`ifdef BP_CFG_CHECKSUM_EN
            csum_n  = '0;
`endif
          end
        end
      end
      st_wait: begin
        data_n = bus.rom_data_i;
        pend_n = ch_en_q;
`ifdef BP_CFG_CHECKSUM_EN
        csum_n = csum_q ^ bus.rom_data_i;
`endif
      end
      st_send: begin
        pend_n = pend_left;
        if (beat_done && !last_beat) begin
`ifdef BP_CFG_CHECKSUM_EN
          if (idx_q == last_idx_lp) begin
            idx_n  = sum_idx_lp;
            data_n = csum_q;
            pend_n = ch_en_q;
          end else begin
            idx_n  = lg_fields_lp'(idx_q + 1'b1);
          end
`else
          idx_n = lg_fields_lp'(idx_q + 1'b1);
`endif
        end
      end
      default: ;
    endcase

    rom_v_n    = (state_n == st_fetch);
    rom_addr_n = (state_n == st_fetch) ? {cfg_n, idx_n} : rom_addr_q;
    busy_n     = (state_n != st_idle);
    done_n     = (state_n == st_done);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cfg_q      <= '0;
      ch_en_q    <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      rom_v_q    <= 1'b0;
      rom_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef BP_CFG_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      cfg_q      <= cfg_n;
      ch_en_q    <= ch_en_n;
      idx_q      <= idx_n;
      data_q     <= data_n;
      pend_q     <= pend_n;
      err_q      <= err_n;
      rom_v_q    <= rom_v_n;
      rom_addr_q <= rom_addr_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
`ifdef BP_CFG_CHECKSUM_EN
      csum_q     <= csum_n;
`endif
    end
  end

  assign bus.rom_v_o    = rom_v_q;
  assign bus.rom_addr_o = rom_addr_q;
  assign bus.pkt_v_o    = pend_q;
  assign bus.pkt_addr_o = idx_q;
  assign bus.pkt_data_o = data_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.error_o    = err_q;
endmodule
